// File: rtl/ahbl_cache_bridge_pkg.sv
// Shared encodings for the AHB-Lite to cache bridge: FSM states, HTRANS/HSIZE
// codes and the latched address-phase record.
package ahbl_cache_bridge_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RD_ISSUE = 3'd1;
    localparam logic [2:0] ST_RD_WAIT  = 3'd2;
    localparam logic [2:0] ST_WR_STALL = 3'd3;
    localparam logic [2:0] ST_ERR1     = 3'd4;
    localparam logic [2:0] ST_ERR2     = 3'd5;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    // Address-phase info kept for the data phase: cache word address and lanes.
    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  mask;
    } aph_t;

endpackage

// File: rtl/ahbl_cache_bridge_if.sv
// AHB-Lite subordinate port plus the cache request port of the bridge.
interface ahbl_cache_bridge_if;
    logic        hsel;
    logic        hready;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic        hready_resp;
    logic        hresp;
    logic [31:0] hrdata;

    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_mask;
    logic [31:0] mem_rdata;
    logic        mem_busy;

    // Bridge view.
    modport slave (
        input  hsel, hready, htrans, hwrite, hsize, haddr, hwdata, mem_rdata, mem_busy,
        output hready_resp, hresp, hrdata, mem_rd_en, mem_wr_en, mem_addr, mem_wdata, mem_mask
    );

    // Bus master / cache environment view.
    modport master (
        output hsel, hready, htrans, hwrite, hsize, haddr, hwdata, mem_rdata, mem_busy,
        input  hready_resp, hresp, hrdata, mem_rd_en, mem_wr_en, mem_addr, mem_wdata, mem_mask
    );
endinterface

// File: rtl/ahbl_cache_bridge.sv
// AHB-Lite subordinate fronting a cache: one-entry posted write buffer,
// stalled reads that never overtake a buffered write, two-cycle ERROR.
module ahbl_cache_bridge
    import ahbl_cache_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = 23
) (
    input  logic             clk,
    input  logic             rst_x,
    ahbl_cache_bridge_if.slave bus
);

    // Word-aligned address bits that reach the cache.
    localparam logic [31:0] ADDR_KEEP = 32'((33'h1 << ADDR_WIDTH) - 33'h1) & 32'hFFFF_FFFC;

    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] a);
        case (size)
            HSIZE_BYTE: lane_mask = 4'b0001 << a;
            HSIZE_HALF: lane_mask = a[1] ? 4'b1100 : 4'b0011;
            default:    lane_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic size_err(input logic [2:0] size, input logic [1:0] a);
        size_err = (size > HSIZE_WORD) ||
                   (size == HSIZE_WORD && a != 2'b00) ||
                   (size == HSIZE_HALF && a[0]);
    endfunction

    logic [2:0]  state, state_nxt;
    aph_t        aph;
    logic        buf_valid;
    logic [31:0] buf_addr, buf_data;
    logic [3:0]  buf_mask;
    logic        guard;
    logic        accept, done, rd_issue, wr_issue, capture;

    assign accept = bus.hsel && bus.hready &&
                    (bus.htrans == HTRANS_NONSEQ || bus.htrans == HTRANS_SEQ);

    // guard blocks back-to-back requests; it also starts set out of reset.
    assign wr_issue = buf_valid && !bus.mem_busy && !guard;
    assign rd_issue = (state == ST_RD_ISSUE) && !buf_valid && !bus.mem_busy && !guard;
    assign capture  = (state == ST_WR_STALL) && !buf_valid;

    always_comb begin
        done = 1'b1;
        case (state)
            ST_RD_ISSUE: done = 1'b0;
            ST_RD_WAIT:  done = !bus.mem_busy;
            ST_WR_STALL: done = !buf_valid;
            ST_ERR1:     done = 1'b0;
            default:     done = 1'b1;
        endcase
    end

    // A completing data phase may overlap the next address phase.
    always_comb begin
        state_nxt = state;
        if (done) begin
            if (!accept)
                state_nxt = ST_IDLE;
            else if (size_err(bus.hsize, bus.haddr[1:0]))
                state_nxt = ST_ERR1;
            else if (bus.hwrite)
                state_nxt = ST_WR_STALL;
            else
                state_nxt = ST_RD_ISSUE;
        end else if (state == ST_RD_ISSUE && rd_issue) begin
            state_nxt = ST_RD_WAIT;
        end else if (state == ST_ERR1) begin
            state_nxt = ST_ERR2;
        end
    end

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            state     <= ST_IDLE;
            aph       <= '0;
            buf_valid <= 1'b0;
            buf_addr  <= '0;
            buf_data  <= '0;
            buf_mask  <= '0;
            guard     <= 1'b1;
        end else begin
            state <= state_nxt;
            guard <= rd_issue || wr_issue;
            if (done && accept)
                aph <= '{addr: bus.haddr & ADDR_KEEP,
                         mask: lane_mask(bus.hsize, bus.haddr[1:0])};
            if (capture) begin
                buf_valid <= 1'b1;
                buf_addr  <= aph.addr;
                buf_data  <= bus.hwdata;
                buf_mask  <= aph.mask;
            end else if (wr_issue) begin
                buf_valid <= 1'b0;
            end
        end
    end

    assign bus.hready_resp = done;
    assign bus.hresp       = (state == ST_ERR1) || (state == ST_ERR2);
    assign bus.hrdata      = (state == ST_RD_WAIT && !bus.mem_busy) ? bus.mem_rdata : '0;

    assign bus.mem_rd_en = rd_issue;
    assign bus.mem_wr_en = wr_issue;
    assign bus.mem_addr  = wr_issue ? buf_addr : (rd_issue ? aph.addr : '0);
    assign bus.mem_wdata = wr_issue ? buf_data : '0;
    assign bus.mem_mask  = wr_issue ? buf_mask : (rd_issue ? aph.mask : '0);

endmodule

// File: doc/ahbl_cache_bridge.md
AHBL_CACHE_BRIDGE -- requirements
Module: ahbl_cache_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 23: number of byte-address bits forwarded to the cache; upper bits are forced to 0.
REQ-002 SHALL have port clk, input, 1: clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_x, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have AHB-Lite subordinate inputs: hsel (1), hready (1, bus-level ready), htrans (2), hwrite (1), hsize (3), haddr (32), hwdata (32).
REQ-005 SHALL have AHB-Lite subordinate outputs: hready_resp (1), hresp (1), hrdata (32).
REQ-006 SHALL have cache-side outputs: mem_rd_en (1), mem_wr_en (1), mem_addr (32), mem_wdata (32), mem_mask (4, byte enables, bit n = byte lane n).
REQ-007 SHALL have cache-side inputs: mem_rdata (32) and mem_busy (1).

Function
REQ-008 Transfer accepted: address phase with hsel=1, hready=1 and htrans[1]=1. IDLE/BUSY htrans produce a zero-wait OKAY response.
REQ-009 Error: hsize>2, hsize=2 with haddr[1:0]!=0, or hsize=1 with haddr[0]=1. Response: cycle 1 hready_resp=0, hresp=1; cycle 2 hready_resp=1, hresp=1. No cache request is issued.
REQ-010 mem_addr = haddr[ADDR_WIDTH-1:2] with bits [1:0]=00 and bits [31:ADDR_WIDTH]=0.
REQ-011 mem_mask: from hsize and haddr[1:0]. Byte: one lane; half: lanes {1,0} or {3,2}; word: 4'b1111. mem_wdata = hwdata unshifted.
REQ-012 Issue rule: mem_rd_en or mem_wr_en pulses high for exactly one cycle, only when mem_busy=0, and never in the cycle directly after a previous pulse (guard cycle). Both are never high together.
REQ-013 Posted write buffer, one entry (addr, data, mask, valid):
- Write data phase, buffer empty: capture hwdata and the address-phase info, hready_resp=1 (zero wait).
- Buffer full: hready_resp=0 until the buffer drains, then capture.
REQ-014 Buffer drain: issue mem_wr_en from the buffer when REQ-012 allows; valid clears in the issue cycle.
REQ-015 Read data phase:
- Hold hready_resp=0 until the buffer is empty, then issue mem_rd_en.
- Complete on the first cycle after issue (excluding the issue cycle) with mem_busy=0: hrdata = mem_rdata combinationally, hready_resp=1, hresp=0.
- Minimum read latency is 1 wait state (cache hit).
REQ-016 Ordering: a read never overtakes a buffered write, so a read of a just-written address returns the new data.
REQ-017 A pending buffered write is drained during following IDLE bus cycles without bus activity.
REQ-018 FSM states: IDLE, RD_ISSUE, RD_WAIT, WR_STALL, ERR1, ERR2. Transitions:
- IDLE -> RD_ISSUE / WR_STALL / ERR1 on an accepted transfer.
- RD_ISSUE -> RD_WAIT after issue.
- RD_WAIT -> IDLE on completion; the next address phase is accepted in the same cycle.
- WR_STALL -> IDLE on capture.
- ERR1 -> ERR2 -> IDLE.
REQ-019 hrdata SHALL be 0 outside read completion cycles.

Reset
REQ-020 While rst_x=0:
- State = IDLE, buffer valid = 0.
- hready_resp = 1, hresp = 0.
- mem_rd_en = mem_wr_en = 0; mem_addr, mem_wdata, mem_mask = 0.
REQ-021 Reset mid-operation discards any in-flight read and any buffered write. No mem_*_en pulse occurs in the first cycle after release.

Structure
REQ-022 Shared package holds the FSM state encoding, the HTRANS codes (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3) and the HSIZE codes.
REQ-023 Single module; no sub-module. The write buffer and mask decode are inline.

Verification
REQ-024 Word write 0x100 = 0xDEADBEEF, mem_busy low: hready_resp=1 in the data phase; mem_wr_en pulses once with mask 4'b1111 and addr 0x100.
REQ-025 Byte write 0xAB to 0x103 (hwdata 0xAB000000) -> mem_mask=4'b1000, mem_wdata=0xAB000000.
REQ-026 Read 0x200, cache returns mem_busy=0 the cycle after issue with mem_rdata 0x12345678 -> one wait state, hrdata=0x12345678.
REQ-027 Write 0x300 then immediately read 0x300 while mem_busy is held high for 10 cycles -> read stalls; mem_wr_en precedes mem_rd_en with at least one guard cycle between them; hrdata = the written value.
REQ-028 Word read at 0x102 -> two-cycle ERROR response (hresp=1 both cycles, hready_resp 0 then 1); no mem_rd_en pulse.
REQ-029 rst_x asserted during RD_WAIT and during a buffered write -> outputs at reset values immediately; no mem_wr_en pulse after release.
